// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem reads, small instruction queue.
// Optional IF_PERF_CNT_EN adds stall/flush/drop performance counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc4,
    input  logic [15:0] redirect_imm16,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt, drop_addr, target, addr_raw;
    logic [31:0]   inst_q [QDEPTH];
    logic [31:0]   pc4_q  [QDEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    logic          push, pop, drop_ack;

    assign target   = redirect_pc4
                    + {{14{redirect_imm16[15]}}, redirect_imm16, 2'b00};
    assign addr_raw = (state == DROP) ? drop_addr : pc;
    assign imem_addr = addr_raw & 32'hFFFF_FFFC;
    assign imem_req  = (state == WAIT) || (state == DROP);

    assign if_valid = (count != '0);
    assign if_inst  = if_valid ? inst_q[head] : NOP_INST;
    assign if_pc4   = if_valid ? pc4_q[head]  : 32'h0;

    assign push = (state == WAIT) && imem_ack && !redirect;
    assign pop  = if_valid && !stall && !redirect;
    assign count_nxt = redirect ? '0
                     : count + CW'(push) - CW'(pop);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_ack  = 1'b0;
        unique case (state)
            IDLE: begin
                if (redirect)
                    pc_nxt = target;
                else if (count < QD)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    pc_nxt    = target;
                    drop_ack  = imem_ack;
                    state_nxt = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = (count_nxt < QD) ? WAIT : IDLE;
                end
            end
            DROP: begin
                if (redirect)
                    pc_nxt = target;
                if (imem_ack) begin
                    drop_ack  = 1'b1;
                    state_nxt = redirect ? IDLE : WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Writes follow the pipeline registers, which update on the falling edge
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            count <= count_nxt;
            if (state == WAIT && redirect && !imem_ack)
                drop_addr <= pc;
            if (redirect) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
            end
        end
    end

    always_ff @(negedge clk) begin
        if (push) begin
            inst_q[tail] <= imem_rdata;
            pc4_q[tail]  <= imem_addr + 32'd4;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (stall && if_valid && perf_stall_cyc != '1)
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (redirect && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (drop_ack && perf_drop_cnt != '1)
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
        end
    end
`endif

endmodule
